mem_stage: RTL and testbench

- Memory-access pipeline stage of the 5-stage LoongArch CPU.
- Receiver end of the execute→memory valid/allow-in handshake.
- Consumes the execute stage's pc, inst, ALU result and the 7-bit pass bundle {res_from_mem, gr_we, dest[4:0]}, plus synchronous data-SRAM read data.
- Selects the final result, hands off to write-back, and supplies forwarding/hazard info to decode.

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/mem_rdata_hold.sv | 36 +++
 rtl/mem_stage.sv | 93 +++++++++
 tb/tb_mem_stage.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared execute/memory/write-back pipeline definitions: bundle widths,
// bit positions inside the pass bundles, and the memory-stage payload.
package pipe_pkg;

    localparam int EX2MEM_SIG_W     = 7;
    localparam int MEM2WB_SIG_W     = 6;
    localparam int RES_FROM_MEM_BIT = 6;
    localparam int GR_WE_BIT        = 5;
    localparam int DEST_LSB         = 0;
    localparam int DEST_W           = 5;

    // Instruction payload carried from execute into the memory stage
    typedef struct packed {
        logic [31:0]             pc;
        logic [31:0]             inst;
        logic [31:0]             alu_result;
        logic [EX2MEM_SIG_W-1:0] sig;
    } ex2mem_t;

endpackage

// File: rtl/mem_rdata_hold.sv
// Captures synchronous SRAM read data on the first occupancy cycle of an
// instruction and replays it for the rest of its residency, so a stalled
// load keeps its value even after the SRAM address moves on.
module mem_rdata_hold #(
    parameter bit HOLD_RDATA = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        accept,
    input  logic [31:0] rdata,
    output logic [31:0] load_data
);

    generate
        if (HOLD_RDATA) begin : g_hold
            logic        first_cycle;
            logic [31:0] hold_reg;

            // first_cycle marks the cycle right after an accept; snapshot rdata then
            always_ff @(posedge clk) begin
                if (!resetn) begin
                    first_cycle <= 1'b0;
                    hold_reg    <= '0;
                end else begin
                    first_cycle <= accept;
                    if (first_cycle) hold_reg <= rdata;
                end
            end

            assign load_data = first_cycle ? rdata : hold_reg;
        end else begin : g_live
            assign load_data = rdata;
        end
    endgenerate

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: receiver end of the execute handshake, picks load
// data or ALU result for write-back, exports forwarding info to decode and
// keeps load-retire / write-back-stall performance counters.
module mem_stage
    import pipe_pkg::*;
#(
    parameter bit HOLD_RDATA = 1'b1,
    parameter int CNT_W      = 32
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    EXU_to_MEM_valid,
    output logic                    MEM_allow_in,
    input  logic [31:0]             EXU_pc_to_MEM,
    input  logic [31:0]             EXU_inst_to_MEM,
    input  logic [31:0]             EXU_alu_result_to_MEM,
    input  logic [EX2MEM_SIG_W-1:0] EXU_signals_pass_to_MEM,
    input  logic [31:0]             data_sram_rdata,
    input  logic                    WB_allow_in,
    output logic                    MEM_to_WB_valid,
    output logic [31:0]             MEM_pc_to_WB,
    output logic [31:0]             MEM_inst_to_WB,
    output logic [31:0]             MEM_final_result_to_WB,
    output logic [MEM2WB_SIG_W-1:0] MEM_signals_pass_to_WB,
    output logic                    MEM_to_IDU_gr_we,
    output logic [DEST_W-1:0]       MEM_to_IDU_dest,
    output logic                    MEM_to_IDU_valid,
    output logic [31:0]             MEM_to_IDU_forward,
    output logic [CNT_W-1:0]        MEM_ld_cnt,
    output logic [CNT_W-1:0]        MEM_stall_cnt
);

    logic        mem_valid;
    ex2mem_t     pl;
    logic        accept;
    logic        res_from_mem;
    logic [31:0] load_data;

    // ready_go is always 1, so only write-back back-pressure blocks the stage
    assign MEM_allow_in = !mem_valid || WB_allow_in;
    assign accept       = EXU_to_MEM_valid && MEM_allow_in;
    assign res_from_mem = pl.sig[RES_FROM_MEM_BIT];

    // Valid bit follows the upstream valid whenever the stage can take a new slot
    always_ff @(posedge clk) begin
        if (!resetn)           mem_valid <= 1'b0;
        else if (MEM_allow_in) mem_valid <= EXU_to_MEM_valid;
    end

    // Payload loads only on a real accept; bubbles leave stale payload behind
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pl <= '0;
        end else if (accept) begin
            pl.pc         <= EXU_pc_to_MEM;
            pl.inst       <= EXU_inst_to_MEM;
            pl.alu_result <= EXU_alu_result_to_MEM;
            pl.sig        <= EXU_signals_pass_to_MEM;
        end
    end

    mem_rdata_hold #(.HOLD_RDATA(HOLD_RDATA)) u_hold (
        .clk       (clk),
        .resetn    (resetn),
        .accept    (accept),
        .rdata     (data_sram_rdata),
        .load_data (load_data)
    );

    // Performance counters wrap naturally at 2^CNT_W
    always_ff @(posedge clk) begin
        if (!resetn) begin
            MEM_ld_cnt    <= '0;
            MEM_stall_cnt <= '0;
        end else begin
            if (mem_valid && WB_allow_in && res_from_mem) MEM_ld_cnt <= MEM_ld_cnt + CNT_W'(1);
            if (mem_valid && !WB_allow_in) MEM_stall_cnt <= MEM_stall_cnt + CNT_W'(1);
        end
    end

    assign MEM_to_WB_valid        = mem_valid;
    assign MEM_pc_to_WB           = pl.pc;
    assign MEM_inst_to_WB         = pl.inst;
    assign MEM_final_result_to_WB = res_from_mem ? load_data : pl.alu_result;
    assign MEM_signals_pass_to_WB = pl.sig[MEM2WB_SIG_W-1:0];

    // Forwarding is unqualified; decode gates it with MEM_to_IDU_valid
    assign MEM_to_IDU_gr_we   = pl.sig[GR_WE_BIT];
    assign MEM_to_IDU_dest    = pl.sig[DEST_LSB +: DEST_W];
    assign MEM_to_IDU_valid   = mem_valid;
    assign MEM_to_IDU_forward = MEM_final_result_to_WB;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against an instruction-level model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ev;
    logic        allow;
    logic [31:0] pc, inst, alu, rdata;
    logic [6:0]  sig;
    logic        wb;
    logic        vld;
    logic [31:0] o_pc, o_inst, o_res, o_fwd;
    logic [5:0]  o_sig;
    logic        o_gr_we, o_ivld;
    logic [4:0]  o_dest;
    logic [31:0] o_ldc, o_stc;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_stage #(.HOLD_RDATA(1'b1), .CNT_W(32)) dut (
        .clk                     (clk),
        .resetn                  (resetn),
        .EXU_to_MEM_valid        (ev),
        .MEM_allow_in            (allow),
        .EXU_pc_to_MEM           (pc),
        .EXU_inst_to_MEM         (inst),
        .EXU_alu_result_to_MEM   (alu),
        .EXU_signals_pass_to_MEM (sig),
        .data_sram_rdata         (rdata),
        .WB_allow_in             (wb),
        .MEM_to_WB_valid         (vld),
        .MEM_pc_to_WB            (o_pc),
        .MEM_inst_to_WB          (o_inst),
        .MEM_final_result_to_WB  (o_res),
        .MEM_signals_pass_to_WB  (o_sig),
        .MEM_to_IDU_gr_we        (o_gr_we),
        .MEM_to_IDU_dest         (o_dest),
        .MEM_to_IDU_valid        (o_ivld),
        .MEM_to_IDU_forward      (o_fwd),
        .MEM_ld_cnt              (o_ldc),
        .MEM_stall_cnt           (o_stc)
    );

    // Model: the resident instruction as a record, plus the load value it saw
    bit          m_occ;
    bit          m_new;    // instruction arrived at the last edge
    logic [31:0] m_pc, m_inst, m_alu, m_ld;
    logic [6:0]  m_sig;
    int unsigned m_ldc, m_stc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output with the model for the current cycle
    task automatic check_model();
        logic [31:0] exp_res;
        if (m_new) m_ld = rdata;   // a load sees the SRAM data of its first cycle
        exp_res = m_sig[6] ? m_ld : m_alu;
        chk("allow_in", 32'(allow), 32'(!m_occ || wb));
        chk("to_wb_valid", 32'(vld), 32'(m_occ));
        chk("idu_valid", 32'(o_ivld), 32'(m_occ));
        chk("pc", o_pc, m_pc);
        chk("inst", o_inst, m_inst);
        chk("final_result", o_res, exp_res);
        chk("forward", o_fwd, exp_res);
        chk("sig_pass", 32'(o_sig), 32'(m_sig[5:0]));
        chk("gr_we", 32'(o_gr_we), 32'(m_sig[5]));
        chk("dest", 32'(o_dest), 32'(m_sig[4:0]));
        chk("ld_cnt", o_ldc, m_ldc);
        chk("stall_cnt", o_stc, m_stc);
    endtask

    task automatic model_edge();
        bit can_take;
        if (!resetn) begin
            m_occ = 0; m_new = 0; m_pc = 0; m_inst = 0; m_alu = 0; m_sig = 0; m_ld = 0;
            m_ldc = 0; m_stc = 0;
            return;
        end
        if (m_occ && wb && m_sig[6]) m_ldc++;
        if (m_occ && !wb) m_stc++;
        can_take = !m_occ || wb;
        m_new = 0;
        if (can_take) begin
            m_occ = ev;
            if (ev) begin
                m_pc = pc; m_inst = inst; m_alu = alu; m_sig = sig; m_new = 1;
            end
        end
    endtask

    // One clock: check just after inputs settle, then advance DUT and model
    task automatic cycle();
        #1 check_model();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input logic [31:0] p, input logic [31:0] a,
                         input logic [6:0] s, input bit w);
        ev = v; pc = p; inst = p ^ 32'h0280_0000; alu = a; sig = s; wb = w;
    endtask

    initial begin
        resetn = 1'b0; rdata = '0;
        drive(0, 0, 0, 0, 1);
        @(posedge clk); model_edge(); @(negedge clk);
        cycle();
        // Reset state
        #1;
        chk("rst_allow", 32'(allow), 32'd1);
        chk("rst_valid", 32'(vld), 32'd0);
        chk("rst_ldcnt", o_ldc, 32'd0);
        chk("rst_result", o_res, 32'd0);

        // ALU passthrough
        resetn = 1'b1;
        drive(1, 32'h1C00_0000, 32'h1234_5678, 7'b0_1_00101, 1);
        cycle();
        drive(0, 0, 0, 0, 1);
        #1;
        chk("alu_valid", 32'(vld), 32'd1);
        chk("alu_result", o_res, 32'h1234_5678);
        chk("alu_sig", 32'(o_sig), 32'h25);
        chk("alu_fwd", o_fwd, 32'h1234_5678);
        cycle();

        // Load, then a 3-cycle write-back stall with SRAM data moving away
        drive(1, 32'h1C00_0004, 32'h0000_0100, 7'b1_1_00011, 1);
        cycle();
        drive(0, 0, 0, 0, 0); rdata = 32'hDEAD_BEEF;
        #1;
        chk("ld_result", o_res, 32'hDEAD_BEEF);
        chk("ld_allow", 32'(allow), 32'd0);
        cycle();
        rdata = 32'h0;
        drive(1, 32'h1C00_0BAD, 32'h5555_5555, 7'b0_1_01111, 0);
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("stall_result", o_res, 32'hDEAD_BEEF);
            chk("stall_pc", o_pc, 32'h1C00_0004);
            cycle();
        end
        drive(0, 0, 0, 0, 1);
        #1;
        chk("stall_cnt3", o_stc, 32'd3);
        chk("ld_cnt_pre", o_ldc, 32'd0);
        cycle();
        #1 chk("ld_cnt1", o_ldc, 32'd1);
        cycle();

        // Back-to-back ALU ops, one retire per cycle
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h1C00_0100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 7'(7'b0_1_00000 + i + 1), 1);
            if (i > 0) begin
                #1;
                chk("b2b_valid", 32'(vld), 32'd1);
                chk("b2b_result", o_res, 32'hA000_0000 + 32'(i - 1));
            end
            cycle();
        end
        drive(0, 0, 0, 0, 1);
        #1 chk("b2b_last", o_res, 32'hA000_0003);
        cycle();

        // Reset while a stalled load is resident
        drive(1, 32'h1C00_0200, 32'h0000_0040, 7'b1_1_00111, 1);
        cycle();
        drive(0, 0, 0, 0, 0); rdata = 32'hCAFE_F00D;
        cycle();
        cycle();
        resetn = 1'b0;
        cycle();
        resetn = 1'b1; wb = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(vld), 32'd0);
        chk("mid_rst_stall", o_stc, 32'd0);
        chk("mid_rst_ld", o_ldc, 32'd0);
        cycle();
        cycle();

        // Randomized traffic with occasional resets
        for (int n = 0; n < 600; n++) begin
            resetn = ($urandom_range(63) != 0);
            drive($urandom_range(3) != 0, $urandom, $urandom, 7'($urandom), $urandom_range(3) != 0);
            rdata = $urandom;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
